// File: rtl/fma16_sched_if.sv
// fma16_sched_if: requester, fma16 datapath and response signals of the shared-fma16 scheduler.
// Optional FMA16_SCHED_FLAGACC_EN adds the per-requester sticky flag signals acc_flags/acc_clr.
interface fma16_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [16*NREQ-1:0]   req_x;
    logic [16*NREQ-1:0]   req_y;
    logic [16*NREQ-1:0]   req_z;
    logic [4*NREQ-1:0]    req_op;
    logic [2*NREQ-1:0]    req_rm;
    logic [15:0]          fma_x;
    logic [15:0]          fma_y;
    logic [15:0]          fma_z;
    logic                 fma_mul;
    logic                 fma_add;
    logic                 fma_negp;
    logic                 fma_negz;
    logic [1:0]           fma_rm;
    logic [15:0]          fma_result;
    logic [3:0]           fma_flags;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [IDW-1:0]       resp_id;
    logic [15:0]          resp_result;
    logic [3:0]           resp_flags;
`ifdef FMA16_SCHED_FLAGACC_EN
    logic [4*NREQ-1:0]    acc_flags;
    logic [NREQ-1:0]      acc_clr;
`endif

    modport slave (
`ifdef FMA16_SCHED_FLAGACC_EN
        output acc_flags,
        input  acc_clr,
`endif
        input  req_valid, req_x, req_y, req_z, req_op, req_rm,
        output req_ready,
        output fma_x, fma_y, fma_z, fma_mul, fma_add, fma_negp, fma_negz, fma_rm,
        input  fma_result, fma_flags,
        output resp_valid, resp_id, resp_result, resp_flags,
        input  resp_ready
    );

    modport master (
`ifdef FMA16_SCHED_FLAGACC_EN
        input  acc_flags,
        output acc_clr,
`endif
        output req_valid, req_x, req_y, req_z, req_op, req_rm,
        input  req_ready,
        input  fma_x, fma_y, fma_z, fma_mul, fma_add, fma_negp, fma_negz, fma_rm,
        output fma_result, fma_flags,
        input  resp_valid, resp_id, resp_result, resp_flags,
        output resp_ready
    );
endinterface

// File: rtl/fma16_sched.sv
// fma16_sched: round-robin sharing of one fma16 unit among NREQ requesters with tagged responses.
// Define FMA16_SCHED_FLAGACC_EN to add per-requester sticky exception flags (acc_flags/acc_clr).
module fma16_sched #(
    parameter int NREQ = 4,
    parameter int LAT  = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input logic            clk,
    input logic            reset,
    fma16_sched_if.slave   bus
);
    localparam int CW = LAT > 1 ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} stateT;

    stateT           state;
    stateT           nextState;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  grantIdx;
    logic [IDW-1:0]  cand;
    logic            found;
    logic            capture;
    logic [CW-1:0]   cnt;
    logic [15:0]     xArr [NREQ];
    logic [15:0]     yArr [NREQ];
    logic [15:0]     zArr [NREQ];
    logic [3:0]      opArr [NREQ];
    logic [1:0]      rmArr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign xArr[i]  = bus.req_x[16*i +: 16];
        assign yArr[i]  = bus.req_y[16*i +: 16];
        assign zArr[i]  = bus.req_z[16*i +: 16];
        assign opArr[i] = bus.req_op[4*i +: 4];
        assign rmArr[i] = bus.req_rm[2*i +: 2];
    end

    // Round-robin pick: scanning from farthest to nearest leaves the first valid requester at or after ptr.
    always_comb begin
        found    = 1'b0;
        grantIdx = '0;
        cand     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDW'((int'(ptr) + k) % NREQ);
            if (bus.req_valid[cand]) begin
                found    = 1'b1;
                grantIdx = cand;
            end
        end
    end

    // Next state and handshake outputs; requests are only granted while idle.
    always_comb begin
        capture        = state == EXEC && cnt == '0;
        bus.req_ready  = (state == IDLE && found) ? NREQ'(1) << grantIdx : '0;
        bus.resp_valid = state == RESP;
        nextState      = state == IDLE ? (found ? EXEC : IDLE) :
                         state == EXEC ? (capture ? RESP : EXEC) :
                         (bus.resp_ready ? IDLE : RESP);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Operand latch on grant, hold countdown, and result capture at the end of the hold window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr             <= '0;
            cnt             <= '0;
            bus.fma_x       <= '0;
            bus.fma_y       <= '0;
            bus.fma_z       <= '0;
            bus.fma_mul     <= 1'b0;
            bus.fma_add     <= 1'b0;
            bus.fma_negp    <= 1'b0;
            bus.fma_negz    <= 1'b0;
            bus.fma_rm      <= '0;
            bus.resp_id     <= '0;
            bus.resp_result <= '0;
            bus.resp_flags  <= '0;
        end else if (state == IDLE && found) begin
            bus.fma_x    <= xArr[grantIdx];
            bus.fma_y    <= yArr[grantIdx];
            bus.fma_z    <= zArr[grantIdx];
            {bus.fma_mul, bus.fma_add, bus.fma_negp, bus.fma_negz} <= opArr[grantIdx];
            bus.fma_rm   <= rmArr[grantIdx];
            bus.resp_id  <= grantIdx;
            ptr          <= IDW'((int'(grantIdx) + 1) % NREQ);
            cnt          <= CW'(LAT - 1);
        end else if (state == EXEC) begin
            if (capture) begin
                bus.resp_result <= bus.fma_result;
                bus.resp_flags  <= bus.fma_flags;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

`ifdef FMA16_SCHED_FLAGACC_EN
    // Sticky flags per requester; a capture on the same cycle as a clear wins with the fresh flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.acc_flags <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (capture && bus.resp_id == IDW'(i))
                    bus.acc_flags[4*i +: 4] <= (bus.acc_clr[i] ? 4'b0 : bus.acc_flags[4*i +: 4]) | bus.fma_flags;
                else if (bus.acc_clr[i])
                    bus.acc_flags[4*i +: 4] <= 4'b0;
            end
        end
    end
`endif
endmodule

// File: tb/tb_fma16_sched.sv
// tb_fma16_sched: randomized self-checking bench for fma16_sched against a transaction-level reference model.
module tb_fma16_sched;
    localparam int NREQ = 4;
    localparam int LAT  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          nChecks = 0;
    int          nErrors = 0;
    int          refPtr = 0;
    logic [15:0] reqX [NREQ];
    logic [15:0] reqY [NREQ];
    logic [15:0] reqZ [NREQ];
    logic [3:0]  reqOp [NREQ];
    logic [1:0]  reqRm [NREQ];
    logic [3:0]  refAcc [NREQ];
    logic [19:0] fmaOut;

    fma16_sched_if #(.NREQ(NREQ)) ifc ();

    fma16_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    for (genvar i = 0; i < NREQ; i++) begin : g_pack
        assign ifc.req_x[16*i +: 16] = reqX[i];
        assign ifc.req_y[16*i +: 16] = reqY[i];
        assign ifc.req_z[16*i +: 16] = reqZ[i];
        assign ifc.req_op[4*i +: 4]  = reqOp[i];
        assign ifc.req_rm[2*i +: 2]  = reqRm[i];
    end

    // Stand-in fma16: exact for the two known vectors, a deterministic scramble otherwise.
    function automatic logic [19:0] fakeFma(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                                            input logic [3:0] op, input logic [1:0] rm);
        if (x == 16'h3C00 && y == 16'h4000 && z == 16'h3C00 && op == 4'b1100) return {4'b0000, 16'h4200};
        if (x == 16'h7BFF && y == 16'h7BFF && op == 4'b1000) return {4'b0101, 16'h7C00};
        return {x[3:0] ^ {2'b00, rm}, x ^ {y[7:0], y[15:8]} ^ z ^ {12'h000, op}};
    endfunction

    assign fmaOut         = fakeFma(ifc.fma_x, ifc.fma_y, ifc.fma_z,
                                    {ifc.fma_mul, ifc.fma_add, ifc.fma_negp, ifc.fma_negz}, ifc.fma_rm);
    assign ifc.fma_result = fmaOut[15:0];
    assign ifc.fma_flags  = fmaOut[19:16];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randOps();
        for (int i = 0; i < NREQ; i++) begin
            reqX[i]  = 16'($urandom);
            reqY[i]  = 16'($urandom);
            reqZ[i]  = 16'($urandom);
            reqOp[i] = 4'($urandom);
            reqRm[i] = 2'($urandom);
        end
    endtask

    function automatic int refWinner(input logic [3:0] mask);
        for (int k = 0; k < NREQ; k++)
            if (mask[(refPtr + k) % NREQ]) return (refPtr + k) % NREQ;
        return -1;
    endfunction

    // One full transaction: grant, operand hold, response with optional back-pressure, handshake.
    task automatic runOp(input logic [3:0] mask, input int hold);
        int          g;
        logic [19:0] e;
        logic [3:0]  gBit;
        ifc.resp_ready = 1'b0;
        ifc.req_valid  = mask;
        #1;
        g    = refWinner(mask);
        gBit = 4'b0001 << g;
        e    = fakeFma(reqX[g], reqY[g], reqZ[g], reqOp[g], reqRm[g]);
        checkVal("grant", 32'(ifc.req_ready), 32'(gBit));
        tick();
        ifc.req_valid = mask & ~gBit;
        refPtr = (g + 1) % NREQ;
        checkVal("fma_x", 32'(ifc.fma_x), 32'(reqX[g]));
        checkVal("fma_y", 32'(ifc.fma_y), 32'(reqY[g]));
        checkVal("fma_z", 32'(ifc.fma_z), 32'(reqZ[g]));
        checkVal("fma_op", 32'({ifc.fma_mul, ifc.fma_add, ifc.fma_negp, ifc.fma_negz}), 32'(reqOp[g]));
        checkVal("fma_rm", 32'(ifc.fma_rm), 32'(reqRm[g]));
        for (int i = 0; i < LAT; i++) begin
            checkVal("exec_resp_valid", 32'(ifc.resp_valid), 32'd0);
            checkVal("exec_req_ready", 32'(ifc.req_ready), 32'd0);
            tick();
        end
        refAcc[g] = refAcc[g] | e[19:16];
        checkVal("resp_valid", 32'(ifc.resp_valid), 32'd1);
        checkVal("resp_id", 32'(ifc.resp_id), 32'(g));
        checkVal("resp_result", 32'(ifc.resp_result), 32'(e[15:0]));
        checkVal("resp_flags", 32'(ifc.resp_flags), 32'(e[19:16]));
`ifdef FMA16_SCHED_FLAGACC_EN
        checkVal("acc_flags", 32'(ifc.acc_flags[4*g +: 4]), 32'(refAcc[g]));
`endif
        for (int i = 0; i < hold; i++) begin
            tick();
            checkVal("hold_valid", 32'(ifc.resp_valid), 32'd1);
            checkVal("hold_result", 32'(ifc.resp_result), 32'(e[15:0]));
            checkVal("hold_id", 32'(ifc.resp_id), 32'(g));
            checkVal("hold_req_ready", 32'(ifc.req_ready), 32'd0);
        end
        ifc.resp_ready = 1'b1;
        #1;
        checkVal("resp_cycle_req_ready", 32'(ifc.req_ready), 32'd0);
        tick();
        ifc.resp_ready = 1'b0;
        ifc.req_valid  = '0;
        checkVal("resp_done", 32'(ifc.resp_valid), 32'd0);
    endtask

    initial begin
        int lastGrant;
        int nGrants;
        int g;
        ifc.req_valid  = '0;
        ifc.resp_ready = 1'b0;
`ifdef FMA16_SCHED_FLAGACC_EN
        ifc.acc_clr    = '0;
`endif
        for (int i = 0; i < NREQ; i++) refAcc[i] = 4'b0;
        randOps();
        #2;
        checkVal("rst_resp_valid", 32'(ifc.resp_valid), 32'd0);
        checkVal("rst_req_ready", 32'(ifc.req_ready), 32'd0);
        checkVal("rst_fma_x", 32'(ifc.fma_x), 32'd0);
        checkVal("rst_resp_result", 32'(ifc.resp_result), 32'd0);
        checkVal("rst_resp_id", 32'(ifc.resp_id), 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // Known vector 1.0*2.0+1.0 from requester 0
        reqX[0] = 16'h3C00; reqY[0] = 16'h4000; reqZ[0] = 16'h3C00; reqOp[0] = 4'b1100; reqRm[0] = 2'b00;
        runOp(4'b0001, 0);

        // Pointer wrap: ptr=1, only requester 3, then 1001 must pick 0
        randOps();
        runOp(4'b1000, 0);
        runOp(4'b1001, 0);

        // Back-pressure with all requesters pending
        randOps();
        runOp(4'b1111, 5);

        // Reset in the middle of EXEC drops the transaction
        randOps();
        ifc.req_valid = 4'b0001;
        #1;
        checkVal("pre_reset_grant", 32'(ifc.req_ready), 32'd1);
        tick();
        ifc.req_valid = '0;
        tick();
        reset = 1'b1;
        #1;
        checkVal("mid_rst_resp_valid", 32'(ifc.resp_valid), 32'd0);
        checkVal("mid_rst_fma_x", 32'(ifc.fma_x), 32'd0);
        checkVal("mid_rst_req_ready", 32'(ifc.req_ready), 32'd0);
        tick();
        reset  = 1'b0;
        refPtr = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkVal("dropped_no_resp", 32'(ifc.resp_valid), 32'd0);
        end

        // Saturated round-robin with resp_ready held high
        ifc.resp_ready = 1'b1;
        ifc.req_valid  = 4'b1111;
        lastGrant = -1;
        nGrants   = 0;
        #1;
        for (int c = 0; c < 20; c++) begin
            if (ifc.req_ready != 4'b0000) begin
                g = refWinner(4'b1111);
                checkVal("rr_grant", 32'(ifc.req_ready), 32'(4'b0001 << g));
                if (lastGrant >= 0) checkVal("rr_spacing", 32'(c - lastGrant), 32'(LAT + 2));
                refPtr    = (g + 1) % NREQ;
                lastGrant = c;
                nGrants++;
            end
            tick();
        end
        checkVal("rr_count", 32'(nGrants), 32'd5);
        ifc.req_valid = '0;
        repeat (4) tick();
        ifc.resp_ready = 1'b0;

        // Randomized traffic
        repeat (30) begin
            randOps();
            runOp(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)));
        end

`ifdef FMA16_SCHED_FLAGACC_EN
        ifc.acc_clr = 4'b1111;
        tick();
        ifc.acc_clr = 4'b0000;
        for (int i = 0; i < NREQ; i++) refAcc[i] = 4'b0;
        checkVal("acc_cleared", 32'(ifc.acc_flags), 32'd0);
        randOps();
        reqX[2] = 16'h7BFF; reqY[2] = 16'h7BFF; reqOp[2] = 4'b1000; reqRm[2] = 2'b00;
        runOp(4'b0100, 0);
        checkVal("acc2_after_ovf", 32'(ifc.acc_flags[11:8]), 32'h5);
        ifc.acc_clr = 4'b0100;
        tick();
        ifc.acc_clr = 4'b0000;
        checkVal("acc2_clr", 32'(ifc.acc_flags[11:8]), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end
endmodule
